// File: rtl/id_stage_pipe.sv
// id_stage_pipe: registered MIPS decode stage (logic, shift, LUI).
// Decodes the IF/ID instruction, resolves operands from the regfile or
// the EX/MEM bypass, stalls on hazards and holds the decoded result in
// an ID/EX register behind a valid/ready handshake.
// Build option: define ID_FWD_EN to enable EX/MEM forwarding. When it is
// undefined, any pending EX/MEM write to a source register stalls instead.
module id_stage_pipe #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic [31:0]       inst_i,
  input  logic              flush_i,
  output logic              reg1_read_o,
  output logic              reg2_read_o,
  output logic [REG_AW-1:0] reg1_addr_o,
  output logic [REG_AW-1:0] reg2_addr_o,
  input  logic [DATA_W-1:0] reg1_data_i,
  input  logic [DATA_W-1:0] reg2_data_i,
  input  logic              ex_wreg_i,
  input  logic              ex_is_load_i,
  input  logic [REG_AW-1:0] ex_wd_i,
  input  logic [DATA_W-1:0] ex_wdata_i,
  input  logic              mem_wreg_i,
  input  logic [REG_AW-1:0] mem_wd_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        aluop_o,
  output logic [2:0]        alusel_o,
  output logic [DATA_W-1:0] reg1_o,
  output logic [DATA_W-1:0] reg2_o,
  output logic [REG_AW-1:0] wd_o,
  output logic              wreg_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic              inst_invalid_o
);

  // Shared ALU operation / result-class encodings
  localparam logic [7:0] EXE_NOP_OP   = 8'b0000_0000;
  localparam logic [7:0] EXE_AND_OP   = 8'b0010_0100;
  localparam logic [7:0] EXE_OR_OP    = 8'b0010_0101;
  localparam logic [7:0] EXE_XOR_OP   = 8'b0010_0110;
  localparam logic [7:0] EXE_NOR_OP   = 8'b0010_0111;
  localparam logic [7:0] EXE_SLL_OP   = 8'b0111_1100;
  localparam logic [7:0] EXE_SRL_OP   = 8'b0000_0010;
  localparam logic [7:0] EXE_SRA_OP   = 8'b0000_0011;
  localparam logic [2:0] EXE_RES_NOP   = 3'b000;
  localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
  localparam logic [2:0] EXE_RES_SHIFT = 3'b010;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_ANDI    = 6'b001100;
  localparam logic [5:0] OP_ORI     = 6'b001101;
  localparam logic [5:0] OP_XORI    = 6'b001110;
  localparam logic [5:0] OP_LUI     = 6'b001111;
  localparam logic [5:0] FN_SLL     = 6'b000000;
  localparam logic [5:0] FN_SRL     = 6'b000010;
  localparam logic [5:0] FN_SRA     = 6'b000011;
  localparam logic [5:0] FN_AND     = 6'b100100;
  localparam logic [5:0] FN_OR      = 6'b100101;
  localparam logic [5:0] FN_XOR     = 6'b100110;
  localparam logic [5:0] FN_NOR     = 6'b100111;

  logic [5:0]        op;
  logic [5:0]        fn;
  logic [REG_AW-1:0] rs;
  logic [REG_AW-1:0] rt;
  logic [REG_AW-1:0] rd;

  logic [7:0]        dec_aluop;
  logic [2:0]        dec_alusel;
  logic              dec_rd1;
  logic              dec_rd2;
  logic              dec_wreg;
  logic [REG_AW-1:0] dec_wd;
  logic [DATA_W-1:0] dec_imm;
  logic              dec_bad;

  logic [DATA_W-1:0] src1;
  logic [DATA_W-1:0] src2;
  logic              hz1;
  logic              hz2;
  logic              hazard;
  logic              capture;

  assign op = inst_i[31:26];
  assign fn = inst_i[5:0];
  assign rs = REG_AW'(inst_i[25:21]);
  assign rt = REG_AW'(inst_i[20:16]);
  assign rd = REG_AW'(inst_i[15:11]);

  // Instruction decode: operation, read enables, destination, immediate
  always_comb begin
    dec_aluop  = EXE_NOP_OP;
    dec_alusel = EXE_RES_NOP;
    dec_rd1    = 1'b0;
    dec_rd2    = 1'b0;
    dec_wreg   = 1'b0;
    dec_wd     = '0;
    dec_imm    = '0;
    dec_bad    = 1'b1;
    case (op)
      OP_SPECIAL: begin
        case (fn)
          FN_AND, FN_OR, FN_XOR, FN_NOR: begin
            dec_bad    = 1'b0;
            dec_alusel = EXE_RES_LOGIC;
            dec_rd1    = 1'b1;
            dec_rd2    = 1'b1;
            dec_wreg   = 1'b1;
            dec_wd     = rd;
            case (fn)
              FN_AND:  dec_aluop = EXE_AND_OP;
              FN_OR:   dec_aluop = EXE_OR_OP;
              FN_XOR:  dec_aluop = EXE_XOR_OP;
              default: dec_aluop = EXE_NOR_OP;
            endcase
          end
          FN_SLL, FN_SRL, FN_SRA: begin
            dec_bad = 1'b0;
            // The all-zero word is the canonical NOP, not a shift of $0
            if (inst_i != 32'h0) begin
              dec_alusel = EXE_RES_SHIFT;
              dec_rd2    = 1'b1;
              dec_wreg   = 1'b1;
              dec_wd     = rd;
              dec_imm    = DATA_W'(inst_i[10:6]);
              case (fn)
                FN_SLL:  dec_aluop = EXE_SLL_OP;
                FN_SRL:  dec_aluop = EXE_SRL_OP;
                default: dec_aluop = EXE_SRA_OP;
              endcase
            end
          end
          default: dec_bad = 1'b1;
        endcase
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        dec_bad    = 1'b0;
        dec_alusel = EXE_RES_LOGIC;
        dec_rd1    = 1'b1;
        dec_wreg   = 1'b1;
        dec_wd     = rt;
        dec_imm    = DATA_W'(inst_i[15:0]);
        case (op)
          OP_ANDI: dec_aluop = EXE_AND_OP;
          OP_ORI:  dec_aluop = EXE_OR_OP;
          default: dec_aluop = EXE_XOR_OP;
        endcase
      end
      OP_LUI: begin
        // LUI is executed as OR of $0 with the shifted immediate
        dec_bad    = 1'b0;
        dec_alusel = EXE_RES_LOGIC;
        dec_aluop  = EXE_OR_OP;
        dec_rd1    = 1'b1;
        dec_wreg   = 1'b1;
        dec_wd     = rt;
        dec_imm    = DATA_W'({inst_i[15:0], 16'h0000});
      end
      default: dec_bad = 1'b1;
    endcase
  end

  assign reg1_read_o = dec_rd1;
  assign reg2_read_o = dec_rd2;
  assign reg1_addr_o = rs;
  assign reg2_addr_o = rt;

`ifdef ID_FWD_EN
  // Operand source select: $0, EX bypass (non-load), MEM bypass, regfile
  always_comb begin
    src1 = reg1_data_i;
    if (rs == '0)
      src1 = '0;
    else if (ex_wreg_i && !ex_is_load_i && ex_wd_i == rs)
      src1 = ex_wdata_i;
    else if (mem_wreg_i && mem_wd_i == rs)
      src1 = mem_wdata_i;
  end

  // Operand source select for the rt port
  always_comb begin
    src2 = reg2_data_i;
    if (rt == '0)
      src2 = '0;
    else if (ex_wreg_i && !ex_is_load_i && ex_wd_i == rt)
      src2 = ex_wdata_i;
    else if (mem_wreg_i && mem_wd_i == rt)
      src2 = mem_wdata_i;
  end

  // Only a load in EX cannot be bypassed
  assign hz1 = dec_rd1 && (rs != '0) && ex_wreg_i && ex_is_load_i && (ex_wd_i == rs);
  assign hz2 = dec_rd2 && (rt != '0) && ex_wreg_i && ex_is_load_i && (ex_wd_i == rt);
`else
  logic unused_fwd;
  assign unused_fwd = ^{ex_is_load_i, ex_wdata_i, mem_wdata_i};

  // Without bypassing, operands come straight from the regfile
  always_comb begin
    src1 = (rs == '0) ? '0 : reg1_data_i;
    src2 = (rt == '0) ? '0 : reg2_data_i;
  end

  // Any in-flight write to a source register stalls until it retires
  assign hz1 = dec_rd1 && (rs != '0) &&
               ((ex_wreg_i && ex_wd_i == rs) || (mem_wreg_i && mem_wd_i == rs));
  assign hz2 = dec_rd2 && (rt != '0) &&
               ((ex_wreg_i && ex_wd_i == rt) || (mem_wreg_i && mem_wd_i == rt));
`endif

  assign hazard   = hz1 || hz2;
  assign in_ready = !hazard && (!out_valid || out_ready);
  assign capture  = in_valid && in_ready && !flush_i;

  // ID/EX register: flush beats capture, capture beats drain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid      <= 1'b0;
      aluop_o        <= EXE_NOP_OP;
      alusel_o       <= EXE_RES_NOP;
      reg1_o         <= '0;
      reg2_o         <= '0;
      wd_o           <= '0;
      wreg_o         <= 1'b0;
      pc_o           <= '0;
      inst_invalid_o <= 1'b0;
    end else if (flush_i) begin
      out_valid <= 1'b0;
    end else if (capture) begin
      out_valid      <= 1'b1;
      aluop_o        <= dec_aluop;
      alusel_o       <= dec_alusel;
      reg1_o         <= dec_rd1 ? src1 : dec_imm;
      reg2_o         <= dec_rd2 ? src2 : dec_imm;
      wd_o           <= dec_wd;
      wreg_o         <= dec_wreg;
      pc_o           <= pc_i;
      inst_invalid_o <= dec_bad;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe with a scoreboard of expected ID/EX
// contents; expected entries are queued at capture and checked while held.
module tb_id_stage_pipe;

  localparam logic [7:0] NOP_OP = 8'h00;
  localparam logic [7:0] AND_OP = 8'h24;
  localparam logic [7:0] OR_OP  = 8'h25;
  localparam logic [7:0] XOR_OP = 8'h26;
  localparam logic [7:0] NOR_OP = 8'h27;
  localparam logic [7:0] SLL_OP = 8'h7C;
  localparam logic [7:0] SRL_OP = 8'h02;
  localparam logic [7:0] SRA_OP = 8'h03;
  localparam logic [2:0] RES_NOP   = 3'd0;
  localparam logic [2:0] RES_LOGIC = 3'd1;
  localparam logic [2:0] RES_SHIFT = 3'd2;

  typedef struct packed {
    logic [7:0]  aluop;
    logic [2:0]  alusel;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] pc;
    logic        inv;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, flush_i;
  logic [31:0] pc_i, inst_i;
  logic        reg1_read_o, reg2_read_o;
  logic [4:0]  reg1_addr_o, reg2_addr_o;
  logic [31:0] reg1_data_i, reg2_data_i;
  logic        ex_wreg_i, ex_is_load_i, mem_wreg_i;
  logic [4:0]  ex_wd_i, mem_wd_i;
  logic [31:0] ex_wdata_i, mem_wdata_i;
  logic        out_valid, out_ready;
  logic [7:0]  aluop_o;
  logic [2:0]  alusel_o;
  logic [31:0] reg1_o, reg2_o, pc_o;
  logic [4:0]  wd_o;
  logic        wreg_o, inst_invalid_o;

  exp_t obs;
  exp_t sb[$];
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  assign obs = {aluop_o, alusel_o, reg1_o, reg2_o, wd_o, wreg_o, pc_o, inst_invalid_o};

  id_stage_pipe #(.DATA_W(32), .ADDR_W(32), .REG_AW(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .pc_i(pc_i), .inst_i(inst_i), .flush_i(flush_i),
    .reg1_read_o(reg1_read_o), .reg2_read_o(reg2_read_o),
    .reg1_addr_o(reg1_addr_o), .reg2_addr_o(reg2_addr_o),
    .reg1_data_i(reg1_data_i), .reg2_data_i(reg2_data_i),
    .ex_wreg_i(ex_wreg_i), .ex_is_load_i(ex_is_load_i), .ex_wd_i(ex_wd_i),
    .ex_wdata_i(ex_wdata_i), .mem_wreg_i(mem_wreg_i), .mem_wd_i(mem_wd_i),
    .mem_wdata_i(mem_wdata_i), .out_valid(out_valid), .out_ready(out_ready),
    .aluop_o(aluop_o), .alusel_o(alusel_o), .reg1_o(reg1_o), .reg2_o(reg2_o),
    .wd_o(wd_o), .wreg_o(wreg_o), .pc_o(pc_o), .inst_invalid_o(inst_invalid_o)
  );

  function automatic exp_t mk(logic [7:0] a, logic [2:0] s, logic [31:0] r1,
                              logic [31:0] r2, logic [4:0] wd, logic w,
                              logic [31:0] pc, logic inv);
    exp_t e;
    e = {a, s, r1, r2, wd, w, pc, inv};
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic quiet();
    in_valid = 0; inst_i = 0; pc_i = 0; flush_i = 0;
    reg1_data_i = 0; reg2_data_i = 0;
    ex_wreg_i = 0; ex_is_load_i = 0; ex_wd_i = 0; ex_wdata_i = 0;
    mem_wreg_i = 0; mem_wd_i = 0; mem_wdata_i = 0;
  endtask

  // One cycle: at the falling edge compare the held result against the
  // scoreboard head, retire it if EX takes it, queue any expected capture.
  task automatic tick(input bit cap, input exp_t e);
    @(negedge clk);
    total++;
    assert (out_valid === (sb.size() != 0)) else begin
      bad++;
      $error("FAIL out_valid observed=%b expected=%0d", out_valid, sb.size() != 0);
    end
    if (out_valid === 1'b1 && sb.size() != 0) begin
      total++;
      assert (obs === sb[0]) else begin
        bad++;
        $error("FAIL held_result observed=%h expected=%h", obs, sb[0]);
      end
      if (out_ready) void'(sb.pop_front());
    end
    if (cap) sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    quiet();
    out_ready = 1;
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_result", 32'(obs != '0), 32'd0);
    chk("reset_valid", 32'(out_valid), 32'd0);
    chk("reset_ready", 32'(in_ready), 32'd1);
    @(negedge clk); rst = 0;
    @(posedge clk); #1;

    // ORI $3,$1,0x00F0
    in_valid = 1; pc_i = 32'h100; inst_i = 32'h3423_00F0;
    reg1_data_i = 32'h1234_0000; reg2_data_i = 32'h5A5A_5A5A; #1;
    chk("ori_rd1", 32'(reg1_read_o), 32'd1);
    chk("ori_rd2", 32'(reg2_read_o), 32'd0);
    chk("ori_addr1", 32'(reg1_addr_o), 32'd1);
    chk("ori_ready", 32'(in_ready), 32'd1);
    tick(1, mk(OR_OP, RES_LOGIC, 32'h1234_0000, 32'h0000_00F0, 5'd3, 1, 32'h100, 0));
    quiet(); tick(0, '0);
    tick(0, '0);

    // OR $5,$1,$2 with EX writing $1 and MEM writing $2
    in_valid = 1; pc_i = 32'h104; inst_i = 32'h0022_2825;
    reg1_data_i = 32'h1111_1111; reg2_data_i = 32'h2222_2222;
    ex_wreg_i = 1; ex_wd_i = 5'd1; ex_wdata_i = 32'hAAAA_0000;
    mem_wreg_i = 1; mem_wd_i = 5'd2; mem_wdata_i = 32'h0000_5555; #1;
`ifdef ID_FWD_EN
    chk("fwd_ready", 32'(in_ready), 32'd1);
    tick(1, mk(OR_OP, RES_LOGIC, 32'hAAAA_0000, 32'h0000_5555, 5'd5, 1, 32'h104, 0));
`else
    chk("raw_stall_both", 32'(in_ready), 32'd0);
    tick(0, '0);
    ex_wreg_i = 0; #1;
    chk("raw_stall_mem", 32'(in_ready), 32'd0);
    tick(0, '0);
    mem_wreg_i = 0; #1;
    chk("raw_clear", 32'(in_ready), 32'd1);
    tick(1, mk(OR_OP, RES_LOGIC, 32'h1111_1111, 32'h2222_2222, 5'd5, 1, 32'h104, 0));
`endif
    quiet(); tick(0, '0);

    // AND $6,$4,$7 behind a load to $4, then to $7
    in_valid = 1; pc_i = 32'h108; inst_i = 32'h0087_3024;
    reg1_data_i = 32'h0F0F_0F0F; reg2_data_i = 32'h00FF_00FF;
    ex_wreg_i = 1; ex_is_load_i = 1; ex_wd_i = 5'd4; ex_wdata_i = 32'hFFFF_FFFF; #1;
    chk("load_use_rs", 32'(in_ready), 32'd0);
    tick(0, '0);
    ex_wd_i = 5'd7; #1;
    chk("load_use_rt", 32'(in_ready), 32'd0);
    tick(0, '0);
    ex_wreg_i = 0; ex_is_load_i = 0; #1;
    chk("load_use_clear", 32'(in_ready), 32'd1);
    tick(1, mk(AND_OP, RES_LOGIC, 32'h0F0F_0F0F, 32'h00FF_00FF, 5'd6, 1, 32'h108, 0));
    quiet(); tick(0, '0);

    // XORI $8,$9,0xFFFF held for three cycles; regfile changes ignored
    out_ready = 0;
    in_valid = 1; pc_i = 32'h10C; inst_i = 32'h3928_FFFF; reg1_data_i = 32'h0000_AAAA; #1;
    tick(1, mk(XOR_OP, RES_LOGIC, 32'h0000_AAAA, 32'h0000_FFFF, 5'd8, 1, 32'h10C, 0));
    quiet(); reg1_data_i = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      #1 chk("hold_ready", 32'(in_ready), 32'd0);
      tick(0, '0);
    end

    // Back-to-back stream: SRL, LUI, NOR, SRA, ANDI, SLL, NOP
    out_ready = 1;
    in_valid = 1; pc_i = 32'h110; inst_i = 32'h000B_5102; reg2_data_i = 32'h8000_0010; #1;
    chk("srl_ready", 32'(in_ready), 32'd1);
    tick(1, mk(SRL_OP, RES_SHIFT, 32'h4, 32'h8000_0010, 5'd10, 1, 32'h110, 0));
    pc_i = 32'h114; inst_i = 32'h3C0E_BEEF; reg1_data_i = 32'hDEAD_DEAD;
    ex_wreg_i = 1; ex_is_load_i = 1; ex_wd_i = 5'd0; ex_wdata_i = 32'h1357_9BDF;
    mem_wreg_i = 1; mem_wd_i = 5'd0; mem_wdata_i = 32'h2468_ACE0; #1;
    chk("reg0_no_stall", 32'(in_ready), 32'd1);
    tick(1, mk(OR_OP, RES_LOGIC, 32'h0, 32'hBEEF_0000, 5'd14, 1, 32'h114, 0));
    quiet(); in_valid = 1;
    pc_i = 32'h118; inst_i = 32'h0022_7827;
    reg1_data_i = 32'hF0F0_F0F0; reg2_data_i = 32'h0000_FFFF; #1;
    chk("nor_addr2", 32'(reg2_addr_o), 32'd2);
    tick(1, mk(NOR_OP, RES_LOGIC, 32'hF0F0_F0F0, 32'h0000_FFFF, 5'd15, 1, 32'h118, 0));
    pc_i = 32'h11C; inst_i = 32'h0011_87C3; reg2_data_i = 32'h8000_0000; #1;
    chk("sra_rd1", 32'(reg1_read_o), 32'd0);
    tick(1, mk(SRA_OP, RES_SHIFT, 32'h1F, 32'h8000_0000, 5'd16, 1, 32'h11C, 0));
    pc_i = 32'h120; inst_i = 32'h3272_8001; reg1_data_i = 32'hFFFF_1234;
    tick(1, mk(AND_OP, RES_LOGIC, 32'hFFFF_1234, 32'h0000_8001, 5'd18, 1, 32'h120, 0));
    pc_i = 32'h124; inst_i = 32'h0015_A040; reg2_data_i = 32'h0000_0003;
    tick(1, mk(SLL_OP, RES_SHIFT, 32'h1, 32'h3, 5'd20, 1, 32'h124, 0));
    pc_i = 32'h128; inst_i = 32'h0;
    tick(1, mk(NOP_OP, RES_NOP, 32'h0, 32'h0, 5'd0, 0, 32'h128, 0));
    quiet(); tick(0, '0);
    tick(0, '0);

    // Undecodable word flows through the handshake
    in_valid = 1; pc_i = 32'h12C; inst_i = 32'hFC00_0000; #1;
    chk("bad_rd1", 32'(reg1_read_o), 32'd0);
    tick(1, mk(NOP_OP, RES_NOP, 32'h0, 32'h0, 5'd0, 0, 32'h12C, 1));
    quiet(); tick(0, '0);

    // Flush while holding, with an undecodable word arriving
    out_ready = 0;
    in_valid = 1; pc_i = 32'h130; inst_i = 32'h3423_00F0; reg1_data_i = 32'h1;
    tick(1, mk(OR_OP, RES_LOGIC, 32'h1, 32'hF0, 5'd3, 1, 32'h130, 0));
    pc_i = 32'h134; inst_i = 32'hFC00_0000; flush_i = 1; #1;
    chk("flush_hold_ready", 32'(in_ready), 32'd0);
    tick(0, '0);
    sb.delete();
    quiet();
    chk("flush_hold_valid", 32'(out_valid), 32'd0);
    tick(0, '0);

    // Flush drops an otherwise acceptable instruction
    out_ready = 1;
    in_valid = 1; pc_i = 32'h138; inst_i = 32'h3423_00F0; flush_i = 1; #1;
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    tick(0, '0);
    quiet();
    chk("flush_in_valid", 32'(out_valid), 32'd0);
    tick(0, '0);

    // Asynchronous reset while a result is held
    out_ready = 0;
    in_valid = 1; pc_i = 32'h13C; inst_i = 32'h3928_FFFF; reg1_data_i = 32'h0000_AAAA;
    tick(1, mk(XOR_OP, RES_LOGIC, 32'h0000_AAAA, 32'h0000_FFFF, 5'd8, 1, 32'h13C, 0));
    quiet(); tick(0, '0);
    #1 rst = 1;
    #1;
    chk("async_rst_result", 32'(obs != '0), 32'd0);
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_ready", 32'(in_ready), 32'd1);
    sb.delete();
    @(negedge clk); rst = 0;
    @(posedge clk); #1;
    out_ready = 1;
    tick(0, '0);

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
